// File: rtl/xram_arbiter_if.sv
// Request/response bundle shared by the two masters, the arbiter and the XRAM port.
// "slave" is the arbiter's view; "master" is the view of the agents around it.
interface xram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              m0_stb;
   logic              m0_wr;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_err;

   logic              m1_stb;
   logic              m1_wr;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_err;

   logic              xram_stb;
   logic              xram_wr;
   logic [ADDR_W-1:0] xram_addr;
   logic [DATA_W-1:0] xram_wdata;
   logic [DATA_W-1:0] xram_rdata;
   logic              xram_ack;

   logic              busy;
   logic              grant;

   modport slave (
      input  m0_stb, m0_wr, m0_addr, m0_wdata,
      output m0_ack, m0_rdata, m0_err,
      input  m1_stb, m1_wr, m1_addr, m1_wdata,
      output m1_ack, m1_rdata, m1_err,
      output xram_stb, xram_wr, xram_addr, xram_wdata,
      input  xram_rdata, xram_ack,
      output busy, grant
   );

   modport master (
      output m0_stb, m0_wr, m0_addr, m0_wdata,
      input  m0_ack, m0_rdata, m0_err,
      output m1_stb, m1_wr, m1_addr, m1_wdata,
      input  m1_ack, m1_rdata, m1_err,
      input  xram_stb, xram_wr, xram_addr, xram_wdata,
      output xram_rdata, xram_ack,
      input  busy, grant
   );
endinterface

// File: rtl/xram_arbiter.sv
// Round-robin arbiter giving two masters one registered XRAM strobe port,
// with a watchdog that completes a stalled access with an error.
module xram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int TMO_W  = 8
) (
   input  logic          clk,
   input  logic          rst,
   xram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   ptr_q, ptr_d;
   logic                   grant_q, grant_d;
   logic                   stb_q, stb_d;
   logic                   wr_q, wr_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [TMO_W-1:0]       wdog_q, wdog_d;
   logic [TMO_W-1:0]       wdog_inc;
   logic [1:0]             ack_q, ack_d;
   logic [1:0]             err_q, err_d;
   logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]             req;
   logic                   win;

   assign req      = {bus.m1_stb, bus.m0_stb};
   // Under contention the pointer decides; a lone requester always wins.
   assign win      = (&req) ? ptr_q : req[1];
   assign wdog_inc = wdog_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      stb_d   = stb_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wdog_d  = wdog_q;
      rdata_d = rdata_q;
      ack_d   = 2'b00;
      err_d   = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = win;
               stb_d   = 1'b1;
               wr_d    = win ? bus.m1_wr    : bus.m0_wr;
               addr_d  = win ? bus.m1_addr  : bus.m0_addr;
               wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
               wdog_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wdog_d = wdog_inc;
            // An ack landing on the timeout cycle still counts as success.
            if (bus.xram_ack) begin
               stb_d          = 1'b0;
               ack_d[grant_q] = 1'b1;
               if (!wr_q) begin
                  rdata_d[grant_q] = bus.xram_rdata;
               end
               state_d = RESP;
            end else if (&wdog_inc) begin
               stb_d            = 1'b0;
               ack_d[grant_q]   = 1'b1;
               err_d[grant_q]   = 1'b1;
               rdata_d[grant_q] = '1;
               state_d          = RESP;
            end
         end
         RESP: begin
            ptr_d   = ~grant_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         grant_q <= 1'b0;
         stb_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wdog_q  <= '0;
         ack_q   <= 2'b00;
         err_q   <= 2'b00;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         stb_q   <= stb_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wdog_q  <= wdog_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.m0_ack     = ack_q[0];
   assign bus.m0_err     = err_q[0];
   assign bus.m0_rdata   = rdata_q[0];
   assign bus.m1_ack     = ack_q[1];
   assign bus.m1_err     = err_q[1];
   assign bus.m1_rdata   = rdata_q[1];
   assign bus.xram_stb   = stb_q;
   assign bus.xram_wr    = wr_q;
   assign bus.xram_addr  = addr_q;
   assign bus.xram_wdata = wdata_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.grant      = grant_q;
endmodule

// File: tb/tb_xram_arbiter.sv
// Bench for xram_arbiter: directed scenarios with literal expectations, then
// random masters/XRAM traffic checked every cycle against a transaction model.
module tb_xram_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int TMO_W  = 4;
   localparam int TMO    = (1 << TMO_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   xram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // master drivers
   logic        mst_stb   [2];
   logic        mst_wr    [2];
   logic [15:0] mst_addr  [2];
   logic [7:0]  mst_wdata [2];
   bit          pend      [2];

   assign bus.m0_stb   = mst_stb[0];
   assign bus.m0_wr    = mst_wr[0];
   assign bus.m0_addr  = mst_addr[0];
   assign bus.m0_wdata = mst_wdata[0];
   assign bus.m1_stb   = mst_stb[1];
   assign bus.m1_wr    = mst_wr[1];
   assign bus.m1_addr  = mst_addr[1];
   assign bus.m1_wdata = mst_wdata[1];

   // XRAM responder controls
   logic       xr_ack_drv   = 1'b0;
   logic [7:0] xr_rdata_drv = 8'h00;
   int         xr_lat       = 0;
   logic [7:0] xr_fixed     = 8'h00;
   bit         xr_rand      = 1'b0;
   bit         xr_late      = 1'b0;
   int         xr_cnt       = 0;
   int         xr_lat_now   = 0;

   assign bus.xram_ack   = xr_ack_drv;
   assign bus.xram_rdata = xr_rdata_drv;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // XRAM: acks a strobe after xr_lat_now extra cycles; 100 means never.
   always @(posedge clk) begin
      #2;
      if (bus.xram_stb) begin
         xr_cnt++;
         if (xr_cnt == 1) begin
            if (xr_rand) xr_lat_now = ($urandom_range(0, 11) == 0) ? 100 : int'($urandom_range(0, 4));
            else         xr_lat_now = xr_lat;
         end
      end else begin
         xr_cnt = 0;
      end
      xr_ack_drv = (bus.xram_stb && xr_cnt == xr_lat_now + 1) || xr_late ||
                   (xr_rand && !bus.xram_stb && $urandom_range(0, 19) == 0);
      xr_rdata_drv = xr_rand ? 8'($urandom) : xr_fixed;
   end

   // Reference model: one outstanding transaction, expected outputs for the next cycle.
   bit         md_txn = 1'b0, md_resp = 1'b0, md_ptr = 1'b0, md_g = 1'b0, md_wr = 1'b0;
   int         md_wait = 0;
   logic [15:0] md_addr = 16'h0;
   logic [7:0]  md_wdata = 8'h0;
   bit         e_stb = 1'b0, e_grant = 1'b0;
   bit         e_ack [2];
   bit         e_err [2];
   logic [7:0] e_rdata [2];

   always @(posedge clk) begin
      e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      e_err[0] = 1'b0; e_err[1] = 1'b0;
      if (rst) begin
         md_txn = 1'b0; md_resp = 1'b0; md_ptr = 1'b0; md_wait = 0;
         e_stb = 1'b0; e_grant = 1'b0;
         e_rdata[0] = 8'h00; e_rdata[1] = 8'h00;
      end else if (!md_txn) begin
         if (mst_stb[0] || mst_stb[1]) begin
            md_g     = (mst_stb[0] && mst_stb[1]) ? md_ptr : mst_stb[1];
            md_wr    = mst_wr[md_g];
            md_addr  = mst_addr[md_g];
            md_wdata = mst_wdata[md_g];
            md_txn   = 1'b1;
            md_resp  = 1'b0;
            md_wait  = 0;
            e_stb    = 1'b1;
            e_grant  = md_g;
         end
      end else if (!md_resp) begin
         md_wait++;
         if (bus.xram_ack) begin
            if (!md_wr) e_rdata[md_g] = bus.xram_rdata;
            e_ack[md_g] = 1'b1;
            md_resp = 1'b1;
            e_stb = 1'b0;
         end else if (md_wait == TMO) begin
            e_rdata[md_g] = 8'hFF;
            e_ack[md_g] = 1'b1;
            e_err[md_g] = 1'b1;
            md_resp = 1'b1;
            e_stb = 1'b0;
         end
      end else begin
         md_ptr  = !md_g;
         md_txn  = 1'b0;
         md_resp = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("xram_stb", bus.xram_stb, e_stb);
         if (e_stb) begin
            chk("xram_wr", bus.xram_wr, md_wr);
            chk("xram_addr", bus.xram_addr, md_addr);
            chk("xram_wdata", bus.xram_wdata, md_wdata);
         end
         chk("busy", bus.busy, md_txn);
         chk("grant", bus.grant, e_grant);
         chk("m0_ack", bus.m0_ack, e_ack[0]);
         chk("m1_ack", bus.m1_ack, e_ack[1]);
         if (e_ack[0]) chk("m0_err", bus.m0_err, e_err[0]);
         if (e_ack[1]) chk("m1_err", bus.m1_err, e_err[1]);
         chk("m0_rdata", bus.m0_rdata, e_rdata[0]);
         chk("m1_rdata", bus.m1_rdata, e_rdata[1]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int g, input logic wr, input logic [15:0] a, input logic [7:0] d);
      mst_stb[g]   = 1'b1;
      mst_wr[g]    = wr;
      mst_addr[g]  = a;
      mst_wdata[g] = d;
   endtask

   task automatic wait_ack(output int who);
      who = -1;
      for (int i = 0; i < 64 && who < 0; i++) begin
         @(negedge clk);
         if (bus.m0_ack === 1'b1)      who = 0;
         else if (bus.m1_ack === 1'b1) who = 1;
      end
      n_cmp++;
      if (who < 0) begin
         n_bad++;
         $display("FAIL ack_wait: got no master ack in 64 cycles, required one (t=%0t)", $time);
      end
   endtask

   task automatic agent(input int g);
      logic ack_g;
      ack_g = (g == 0) ? bus.m0_ack : bus.m1_ack;
      if (pend[g]) begin
         if (ack_g) begin
            if ($urandom_range(0, 2) == 0) begin
               req(g, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
            end else begin
               mst_stb[g] = 1'b0;
               pend[g] = 1'b0;
            end
         end else if (mst_stb[g] && bus.xram_stb && (bus.grant == (g == 1)) &&
                      $urandom_range(0, 15) == 0) begin
            mst_stb[g] = 1'b0;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         req(g, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
         pend[g] = 1'b1;
      end
   endtask

   initial begin
      int who;
      int n;
      for (int g = 0; g < 2; g++) begin
         mst_stb[g] = 1'b0; mst_wr[g] = 1'b0; mst_addr[g] = 16'h0; mst_wdata[g] = 8'h0;
         pend[g] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_xram_stb", bus.xram_stb, 32'd0);
      chk("rst_xram_addr", bus.xram_addr, 32'd0);
      chk("rst_busy", bus.busy, 32'd0);
      chk("rst_grant", bus.grant, 32'd0);
      chk("rst_m0_rdata", bus.m0_rdata, 32'd0);

      // m0 read 0x1234, XRAM acks one cycle after the strobe with 0xA5
      xr_fixed = 8'hA5; xr_lat = 1;
      cyc(); req(0, 1'b0, 16'h1234, 8'h00);
      cyc(); @(negedge clk);
      chk("d1_c1_stb", bus.xram_stb, 32'd1);
      chk("d1_c1_addr", bus.xram_addr, 32'h1234);
      cyc(); @(negedge clk);
      chk("d1_c2_stb", bus.xram_stb, 32'd1);
      chk("d1_c2_ack", bus.m0_ack, 32'd0);
      cyc(); @(negedge clk);
      chk("d1_c3_ack", bus.m0_ack, 32'd1);
      chk("d1_c3_rdata", bus.m0_rdata, 32'hA5);
      chk("d1_c3_err", bus.m0_err, 32'd0);
      chk("d1_c3_m1ack", bus.m1_ack, 32'd0);
      cyc(); mst_stb[0] = 1'b0;

      // simultaneous pair after reset; m0 re-requests at once, so m1 must win next
      cyc(); rst = 1'b1;
      cyc(); rst = 1'b0;
      xr_lat = 0; xr_fixed = 8'h5A;
      req(0, 1'b0, 16'h0100, 8'h00);
      req(1, 1'b0, 16'h0200, 8'h00);
      wait_ack(who); chk("rr_first", who, 32'd0);
      cyc(); mst_addr[0] = 16'h0101;
      wait_ack(who); chk("rr_second", who, 32'd1);
      cyc(); mst_stb[1] = 1'b0;
      wait_ack(who); chk("rr_third", who, 32'd0);
      cyc(); mst_stb[0] = 1'b0;

      // m1 write leaves m1_rdata untouched
      cyc(); req(1, 1'b1, 16'h00FF, 8'h3C);
      cyc(); @(negedge clk);
      chk("wr_xram_wr", bus.xram_wr, 32'd1);
      chk("wr_xram_addr", bus.xram_addr, 32'h00FF);
      chk("wr_xram_wdata", bus.xram_wdata, 32'h3C);
      wait_ack(who); chk("wr_who", who, 32'd1);
      chk("wr_m1_rdata", bus.m1_rdata, 32'h5A);
      cyc(); mst_stb[1] = 1'b0;

      // XRAM never acks: error completion at cycle 2**TMO_W, late ack ignored
      cyc(); xr_lat = 100; req(0, 1'b0, 16'h0042, 8'h00);
      n = 0;
      @(negedge clk);
      while (bus.m0_ack !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_ack_cycle", n, 32'd16);
      chk("tmo_err", bus.m0_err, 32'd1);
      chk("tmo_rdata", bus.m0_rdata, 32'hFF);
      cyc(); mst_stb[0] = 1'b0; xr_late = 1'b1;
      cyc(); xr_late = 1'b0;
      @(negedge clk);
      chk("tmo_late_busy", bus.busy, 32'd0);
      chk("tmo_late_ack", bus.m0_ack, 32'd0);
      cyc(); xr_lat = 2; xr_fixed = 8'h11; req(0, 1'b0, 16'h0043, 8'h00);
      wait_ack(who); chk("tmo_next_who", who, 32'd0);
      chk("tmo_next_rdata", bus.m0_rdata, 32'h11);
      chk("tmo_next_err", bus.m0_err, 32'd0);
      cyc(); mst_stb[0] = 1'b0;

      // m0 holds stb continuously, m1 joins mid-transaction
      cyc(); xr_lat = 1; req(0, 1'b0, 16'h0010, 8'h00);
      cyc(); cyc(); req(1, 1'b0, 16'h0020, 8'h00);
      wait_ack(who); chk("hold_first", who, 32'd0);
      wait_ack(who); chk("hold_second", who, 32'd1);
      cyc(); mst_stb[1] = 1'b0;
      wait_ack(who); chk("hold_third", who, 32'd0);
      cyc(); mst_stb[0] = 1'b0;

      // reset during ISSUE aborts silently and restores the pointer to m0
      cyc(); xr_lat = 100; req(0, 1'b0, 16'h0077, 8'h00);
      cyc(); cyc(); rst = 1'b1;
      cyc(); rst = 1'b0; mst_stb[0] = 1'b0;
      @(negedge clk);
      chk("rst_mid_stb", bus.xram_stb, 32'd0);
      chk("rst_mid_busy", bus.busy, 32'd0);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) n++;
      end
      chk("rst_mid_no_ack", n, 32'd0);
      cyc(); xr_lat = 0;
      req(0, 1'b0, 16'h0300, 8'h00);
      req(1, 1'b0, 16'h0400, 8'h00);
      wait_ack(who); chk("rst_ptr_first", who, 32'd0);
      cyc(); mst_stb[0] = 1'b0;
      wait_ack(who); chk("rst_ptr_second", who, 32'd1);
      cyc(); mst_stb[1] = 1'b0;

      // random traffic
      xr_rand = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         cyc();
         if (rst) begin
            rst = 1'b0;
            for (int g = 0; g < 2; g++) if (!mst_stb[g]) pend[g] = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
         end
         for (int g = 0; g < 2; g++) agent(g);
      end
      cyc();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL global_timeout: bench still running at t=%0t, required to finish earlier", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "bench time limit reached");
   end
endmodule
